// File: rtl/control_multi.sv
// control_multi -- main control FSM for the multi-cycle MIPS datapath.
// Steps the shared-memory, single-ALU datapath through fetch, decode,
// execute, memory and writeback for R-format, lw, sw, beq and j. Memory
// states wait on mem_ready so slow instruction/data memory can stall it.
// ALUOp is left for the separate ALU control block to decode.
// Optional build macro CONTROL_MULTI_ADDI_EN adds addi (opcode 0x08) via
// states ADDIEX(10) and ADDIWB(11).
module control_multi #(
   parameter bit ILLEGAL_HALT = 1'b1  // 1: unknown opcode halts, 0: skip it
) (
   input  logic       clk,
   input  logic       reset,        // asynchronous, active-low
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [3:0] state,
   output logic       halted
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_HALT   = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   state_t state_q;
   state_t state_d;

   // State register; reset drops straight back to FETCH, even mid-wait.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state and Moore output decode. While reset is low every output is
   // held at 0 so no write enable leaks out before the register clears.
   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      halted      = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            // IR and PC+4 are captured only on the cycle memory answers.
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Branch target PC + (signext << 2) computed speculatively.
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
`ifdef CONTROL_MULTI_ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`endif
               default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = S_RWB;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            state_d  = S_FETCH;
         end
`ifdef CONTROL_MULTI_ADDI_EN
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
`endif
         default: begin
            // HALT, plus any stray encoding, which behaves as HALT and then
            // settles in the real HALT state.
            halted  = 1'b1;
            state_d = S_HALT;
         end
      endcase

      if (!reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         MemtoReg    = 1'b0;
         PCSource    = 2'b00;
         ALUOp       = 2'b00;
         ALUSrcA     = 1'b0;
         ALUSrcB     = 2'b00;
         RegWrite    = 1'b0;
         RegDst      = 1'b0;
         halted      = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_control_multi.sv
// tb_control_multi -- self-checking bench for control_multi. A second
// instance built with ILLEGAL_HALT=0 runs in lockstep to cover the
// skip-illegal-opcode variant.
module tb_control_multi;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;

   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic       ALUSrcA, RegWrite, RegDst, halted;
   logic [3:0] state;

   logic       PCWrite0, PCWriteCond0, IorD0, MemRead0, MemWrite0, IRWrite0, MemtoReg0;
   logic [1:0] PCSource0, ALUOp0, ALUSrcB0;
   logic       ALUSrcA0, RegWrite0, RegDst0, halted0;
   logic [3:0] state0;

   int errors = 0;
   int checks = 0;
   bit chk0   = 1'b1;

   always #5 clk = ~clk;

   control_multi #(.ILLEGAL_HALT(1'b1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .RegDst(RegDst), .state(state), .halted(halted)
   );

   control_multi #(.ILLEGAL_HALT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite0), .PCWriteCond(PCWriteCond0), .IorD(IorD0),
      .MemRead(MemRead0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
      .MemtoReg(MemtoReg0), .PCSource(PCSource0), .ALUOp(ALUOp0),
      .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .RegWrite(RegWrite0),
      .RegDst(RegDst0), .state(state0), .halted(halted0)
   );

   wire [16:0] outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
                       RegDst, halted};

   // Control word each state must present, straight from the state table.
   function automatic logic [16:0] exp_out(int st, bit mr);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, hlt;
      logic [1:0] pcs, aop, asb;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, hlt} = '0;
      pcs = 2'b00; aop = 2'b00; asb = 2'b00;
      case (st)
         0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
         1: asb = 2'b11;
         2: begin asa = 1; asb = 2'b10; end
         3: begin mrd = 1; iord = 1; end
         4: begin rw = 1; m2r = 1; end
         5: begin mwr = 1; iord = 1; end
         6: begin asa = 1; aop = 2'b10; end
         7: begin rw = 1; rd = 1; end
         8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         9: begin pcw = 1; pcs = 2'b10; end
`ifdef CONTROL_MULTI_ADDI_EN
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
`endif
         default: hlt = 1;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcs, aop, asa, asb, rw, rd, hlt};
   endfunction

   // Expected per-cycle state trace and mem_ready pattern for one instruction.
   int exp_st[$];
   bit mr_q[$];

   task automatic add_mem(int st, int waits);
      for (int i = 0; i < waits; i++) begin exp_st.push_back(st); mr_q.push_back(1'b0); end
      exp_st.push_back(st); mr_q.push_back(1'b1);
   endtask

   task automatic add_plain(int st);
      exp_st.push_back(st); mr_q.push_back(1'($urandom_range(0, 1)));
   endtask

   task automatic build(logic [5:0] op, int fw, int mw);
      exp_st.delete(); mr_q.delete();
      add_mem(0, fw);
      add_plain(1);
      case (op)
         6'h00: begin add_plain(6); add_plain(7); end
         6'h23: begin add_plain(2); add_mem(3, mw); add_plain(4); end
         6'h2B: begin add_plain(2); add_mem(5, mw); end
         6'h04: add_plain(8);
         6'h02: add_plain(9);
`ifdef CONTROL_MULTI_ADDI_EN
         6'h08: begin add_plain(10); add_plain(11); end
`endif
         default: add_plain(15);
      endcase
   endtask

   function automatic int base_lat(logic [5:0] op);
      case (op)
         6'h23:        return 5;
         6'h04, 6'h02: return 3;
         default:      return 4;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called just after a rising edge: drive inputs, check this cycle,
   // then advance to just after the next rising edge.
   task automatic step(logic [5:0] op, int st, bit mr, string tag);
      opcode    = op;
      mem_ready = mr;
      #1;
      check({tag, " state"}, 32'(state), 32'(st));
      check({tag, " outs"}, 32'(outs), 32'(exp_out(st, mr)));
      if (chk0) check({tag, " state(skip-illegal)"}, 32'(state0), 32'(st));
      @(posedge clk); #1;
   endtask

   task automatic run_instr(logic [5:0] op, int fw, int mw, int lat, string tag);
      build(op, fw, mw);
      for (int i = 0; i < lat; i++)
         step(op, (i < exp_st.size()) ? exp_st[i] : 0, (i < mr_q.size()) ? mr_q[i] : 1'b1, tag);
      #1;
      check({tag, " back to FETCH"}, 32'(state), 32'd0);
   endtask

   typedef struct {
      logic [5:0] op;
      int         fw;
      int         mw;
      int         lat;
   } vec_t;

   initial begin
      vec_t vecs[$];
      logic [5:0] ops[$];
      logic [5:0] op;
      int fw, mw;

      vecs.push_back('{6'h00, 0, 0, 4});
      vecs.push_back('{6'h23, 2, 3, 10});
      vecs.push_back('{6'h2B, 0, 0, 4});
      vecs.push_back('{6'h04, 0, 0, 3});
      vecs.push_back('{6'h02, 0, 0, 3});
      vecs.push_back('{6'h2B, 1, 2, 7});
      vecs.push_back('{6'h00, 3, 0, 7});
      vecs.push_back('{6'h04, 1, 0, 4});
      vecs.push_back('{6'h23, 0, 0, 5});
`ifdef CONTROL_MULTI_ADDI_EN
      vecs.push_back('{6'h08, 0, 0, 4});
      vecs.push_back('{6'h08, 1, 0, 5});
`endif
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02};
`ifdef CONTROL_MULTI_ADDI_EN
      ops.push_back(6'h08);
`endif

      // Reset held low for three cycles with the memory ready.
      reset = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("reset state", 32'(state), 32'd0);
         check("reset outs", 32'(outs), 32'd0);
      end
      reset = 1'b1;
      run_instr(6'h00, 0, 0, 4, "rtype after reset");

      // Directed instruction table.
      foreach (vecs[k])
         run_instr(vecs[k].op, vecs[k].fw, vecs[k].mw, vecs[k].lat,
                   $sformatf("vec%0d op%02h", k, vecs[k].op));

      // Random instruction stream with random memory stalls.
      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, ops.size() - 1)];
         fw = $urandom_range(0, 2);
         mw = $urandom_range(0, 3);
         run_instr(op, fw, mw, base_lat(op) + fw + (op == 6'h23 || op == 6'h2B ? mw : 0),
                   $sformatf("rnd%0d op%02h", n, op));
      end

      // Reset asserted asynchronously while lw waits in MEMRD.
      step(6'h23, 0, 1'b1, "async lw");
      step(6'h23, 1, 1'b0, "async lw");
      step(6'h23, 2, 1'b0, "async lw");
      mem_ready = 1'b0;
      #1;
      check("async pre state", 32'(state), 32'd3);
      check("async pre MemRead", 32'(MemRead), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async outs drop", 32'(outs), 32'd0);
      check("async state drop", 32'(state), 32'd0);
      @(posedge clk); #1;
      check("async held outs", 32'(outs), 32'd0);
      reset = 1'b1;
      run_instr(6'h02, 0, 0, 3, "j after async reset");

      // Illegal opcode: the halting build parks in HALT, the other skips it.
      step(6'h3F, 0, 1'b1, "illegal");
      chk0 = 1'b0;
      step(6'h3F, 1, 1'b1, "illegal");
      check("skip-illegal back to FETCH", 32'(state0), 32'd0);
      for (int i = 0; i < 20; i++)
         step(6'h3F, 15, 1'($urandom_range(0, 1)), "halt");
      reset = 1'b0;
      #1;
      check("halt reset state", 32'(state), 32'd0);
      check("halt reset outs", 32'(outs), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      chk0 = 1'b1;
      run_instr(6'h00, 0, 0, 4, "rtype after halt");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
